dmem_lsu: RTL

- Parametrised byte-lane data memory with load/store unit for the RISC-V pipeline MEM stage; supersedes the fixed 512-byte, combinationally-steered data memory.
- Handles the full RV32I load/store set (LB, LH, LW, LBU, LHU, SB, SH, SW) with correct per-lane extraction and sign extension.
- Adds a req/ready handshake with configurable wait states, so the hazard unit stalls on ready=0, plus optional misalignment trapping.

---
 rtl/dmem_lsu.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-lane data memory with RV32I load/store unit for the MEM stage.
// Accepts one access per req/ready handshake. WAIT_STATES stretches each access
// by that many cycles, and ready is held low while the access is in flight.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word accesses are trapped: a misaligned store writes nothing, a misaligned
// load returns zero, and misalign pulses together with done.

// One byte lane of the storage array. Reads are combinational, writes happen on
// the clock edge, and the contents are never reset.
module dmem_lane #(
  parameter int IW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem_q [0:(1<<IW)-1];

  // byte write when this lane is enabled
  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
  end

  assign rdata = mem_q[idx];
endmodule

module dmem_lsu #(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] a,
  input  logic [DATA_W-1:0]     wd,
  input  logic [2:0]            Funct3,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_W-1:0]     rd,
  output logic                  misalign
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int IW        = DM_ADDRESS - 2;

  generate
    if (DATA_W != 32) begin : g_bad_data_w
      $error("dmem_lsu: DATA_W must be 32");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
      $error("dmem_lsu: WAIT_STATES must be in 0..15");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DM_ADDRESS-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]       wd_q, wd_d;
  logic [2:0]              f3_q, f3_d;
  logic                    ld_q, ld_d;
  logic                    done_q, done_d;
  logic [DATA_W-1:0]       rd_q, rd_d;
  logic                    mis_q, mis_d;

  logic                    accept;
  logic                    acc_fire;
  logic [DM_ADDRESS-1:0]   acc_a;
  logic [DATA_W-1:0]       acc_wd;
  logic [2:0]              acc_f3;
  logic                    acc_ld;

  logic                    is_b, is_h, is_w, mis;
  logic [NUM_LANES-1:0]    lane_be;
  logic [NUM_LANES-1:0][7:0] lane_wd;
  logic [NUM_LANES-1:0][7:0] lane_rd;
  logic [7:0]              sel_b;
  logic [15:0]             sel_h;
  logic [DATA_W-1:0]       ld_val;

  assign accept = req & (state_q == S_IDLE) & (MemRead | MemWrite);

  // Pick the live request (zero wait states) or the captured one at the end of WAIT.
  // Outside WAIT the captured fields are never used, so the mux is keyed on state.
  always_comb begin
    acc_fire = (WAIT_STATES == 0) ? accept
                                  : ((state_q == S_WAIT) && (cnt_q == 4'd1));
    if (state_q == S_WAIT) begin
      acc_a  = addr_q;
      acc_wd = wd_q;
      acc_f3 = f3_q;
      acc_ld = ld_q;
    end else begin
      acc_a  = a;
      acc_wd = wd;
      acc_f3 = Funct3;
      acc_ld = MemRead;
    end
  end

  // Decode the access size. Store codes 100/101 are undefined and treated as a word.
  always_comb begin
    is_b = (acc_f3[1:0] == 2'b00) && (acc_ld || !acc_f3[2]);
    is_h = (acc_f3[1:0] == 2'b01) && (acc_ld || !acc_f3[2]);
    is_w = !is_b && !is_h;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis  = (is_h && acc_a[0]) || (is_w && (acc_a[1:0] != 2'b00));
`else
    mis  = 1'b0;
`endif
  end

  // Store lane enables and lane data. The data is replicated so any lane can take it.
  always_comb begin
    lane_be = '0;
    if (is_b)      lane_be[acc_a[1:0]] = 1'b1;
    else if (is_h) lane_be = acc_a[1] ? 4'b1100 : 4'b0011;
    else           lane_be = 4'b1111;
    if (!acc_fire || acc_ld || mis) lane_be = '0;

    if (is_b)      lane_wd = {NUM_LANES{acc_wd[7:0]}};
    else if (is_h) lane_wd = {2{acc_wd[15:0]}};
    else           lane_wd = acc_wd;
  end

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      dmem_lane #(.IW(IW)) u_lane (
        .clk   (clk),
        .we    (lane_be[i]),
        .idx   (acc_a[DM_ADDRESS-1:2]),
        .wdata (lane_wd[i]),
        .rdata (lane_rd[i])
      );
    end
  endgenerate

  // Load extraction. Funct3[2] selects zero extension (LBU/LHU).
  always_comb begin
    sel_b = lane_rd[acc_a[1:0]];
    sel_h = acc_a[1] ? {lane_rd[3], lane_rd[2]} : {lane_rd[1], lane_rd[0]};
    if (is_b)      ld_val = acc_f3[2] ? {24'h0, sel_b} : {{24{sel_b[7]}}, sel_b};
    else if (is_h) ld_val = acc_f3[2] ? {16'h0, sel_h} : {{16{sel_h[15]}}, sel_h};
    else           ld_val = lane_rd;
    if (mis) ld_val = '0;
  end

  // Next-state logic: capture on accept, count the wait states down, flag completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    f3_d    = f3_q;
    ld_d    = ld_q;
    done_d  = acc_fire;
    mis_d   = acc_fire & mis;
    rd_d    = (acc_fire && acc_ld) ? ld_val : rd_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d = a;
          wd_d   = wd;
          f3_d   = Funct3;
          ld_d   = MemRead;
          if (WAIT_STATES != 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and registered outputs. A reset during WAIT abandons the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wd_q    <= '0;
      f3_q    <= 3'd0;
      ld_q    <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      f3_q    <= f3_d;
      ld_q    <= ld_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      mis_q   <= mis_d;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign done     = done_q;
  assign rd       = rd_q;
  assign misalign = mis_q;
endmodule
